clock_set_ctrl: RTL and testbench

- Mode/setting controller for the digital clock.
- Sequences display modes and time/alarm setting from two push-buttons.
- Issues single-cycle adjust pulses to the time counter chain, holds the alarm set-point (BCD), and drives a per-digit blank mask so the field being set blinks.
- Sits between the debounced button inputs and the time/alarm/display datapath; all timing is derived from 1 kHz and 1 Hz enable ticks.

---
 rtl/clock_set_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Mode and setting controller for the digital clock. Two debounced buttons
// step through the display and setting modes and adjust the time or the alarm.
// Time changes go out as single-cycle pulses to the time counter chain. The
// alarm set-point is held here in BCD. A per-digit blank mask makes the field
// being set blink.
//
// Ports
//   CP         system clock (all logic on posedge)
//   nCR        synchronous active-low reset
//   tick_1kHz  one-cycle enable at 1 kHz (auto-repeat and blink timing)
//   tick_1Hz   one-cycle enable at 1 Hz (set-state timeout)
//   KeyMode    mode button level, 1 = pressed
//   KeyInc     increment button level, 1 = pressed
//   Mode       current state: 0 SHOW_HM, 1 SHOW_MS, 2 SET_HR, 3 SET_MIN,
//              4 SET_ALM_HR, 5 SET_ALM_MIN
//   AdjHr      one-cycle pulse: increment hours
//   AdjMin     one-cycle pulse: increment minutes
//   AlmHr      alarm hour, BCD 00..23
//   AlmMin     alarm minute, BCD 00..59
//   AlarmOn    alarm enable
//   BlankMask  bit3..0 = seg4..seg1, 1 = digit blanked
module clock_set_ctrl #(
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 200,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick_1kHz,
  input  logic       tick_1Hz,
  input  logic       KeyMode,
  input  logic       KeyInc,
  output logic [2:0] Mode,
  output logic       AdjHr,
  output logic       AdjMin,
  output logic [7:0] AlmHr,
  output logic [7:0] AlmMin,
  output logic       AlarmOn,
  output logic [3:0] BlankMask
);

  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int BW   = $clog2(BLINK_MS + 1);
  localparam int TW   = $clog2(TIMEOUT_S + 1);

  typedef enum logic [2:0] {
    SHOW_HM     = 3'd0,
    SHOW_MS     = 3'd1,
    SET_HR      = 3'd2,
    SET_MIN     = 3'd3,
    SET_ALM_HR  = 3'd4,
    SET_ALM_MIN = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic            mode_hist_reg, inc_hist_reg;
  logic [RW-1:0]   rep_cnt_reg, rep_cnt_next;
  logic            rep_started_reg, rep_started_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic [BW-1:0]   blink_cnt_reg, blink_cnt_next;
  logic            blank_phase_reg, blank_phase_next;
  logic            adj_hr_reg, adj_hr_next;
  logic            adj_min_reg, adj_min_next;
  logic [7:0]      alm_hr_reg, alm_hr_next;
  logic [7:0]      alm_min_reg, alm_min_next;
  logic            alarm_on_reg, alarm_on_next;
  logic [3:0]      blank_mask_reg, blank_mask_next;

  logic mode_ev, inc_ev, inc_held, set_state, rep_hit, strobe;
  logic inc_act, activity, timeout, state_chg;

  function automatic logic [7:0] bcd_inc_hr(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge CP) begin
    if (!nCR) begin
      state_reg       <= SHOW_HM;
      mode_hist_reg   <= 1'b0;
      inc_hist_reg    <= 1'b0;
      rep_cnt_reg     <= '0;
      rep_started_reg <= 1'b0;
      to_cnt_reg      <= '0;
      blink_cnt_reg   <= '0;
      blank_phase_reg <= 1'b0;
      adj_hr_reg      <= 1'b0;
      adj_min_reg     <= 1'b0;
      alm_hr_reg      <= 8'h07;
      alm_min_reg     <= 8'h00;
      alarm_on_reg    <= 1'b0;
      blank_mask_reg  <= 4'b0000;
    end else begin
      state_reg       <= state_next;
      mode_hist_reg   <= KeyMode;
      inc_hist_reg    <= KeyInc;
      rep_cnt_reg     <= rep_cnt_next;
      rep_started_reg <= rep_started_next;
      to_cnt_reg      <= to_cnt_next;
      blink_cnt_reg   <= blink_cnt_next;
      blank_phase_reg <= blank_phase_next;
      adj_hr_reg      <= adj_hr_next;
      adj_min_reg     <= adj_min_next;
      alm_hr_reg      <= alm_hr_next;
      alm_min_reg     <= alm_min_next;
      alarm_on_reg    <= alarm_on_next;
      blank_mask_reg  <= blank_mask_next;
    end
  end

  always_comb begin
    mode_ev   = KeyMode & ~mode_hist_reg;
    inc_ev    = KeyInc & ~inc_hist_reg;
    // Held means pressed on this and the previous cycle. The press cycle itself
    // therefore never counts toward the repeat delay.
    inc_held  = KeyInc & inc_hist_reg;
    set_state = (state_reg == SET_HR) || (state_reg == SET_MIN) ||
                (state_reg == SET_ALM_HR) || (state_reg == SET_ALM_MIN);
    rep_hit   = rep_started_reg ? (rep_cnt_reg == RW'(REPEAT_PER - 1))
                                : (rep_cnt_reg == RW'(REPEAT_DLY - 1));
    strobe    = set_state & inc_held & tick_1kHz & rep_hit;
    // A mode change in the same cycle swallows the increment.
    inc_act   = (inc_ev | strobe) & ~mode_ev;
    activity  = mode_ev | inc_ev | strobe;
    timeout   = set_state & tick_1Hz & ~activity &
                (to_cnt_reg == TW'(TIMEOUT_S - 1));

    state_next = state_reg;
    case (state_reg)
      SHOW_HM:     if (mode_ev) state_next = SHOW_MS;
      SHOW_MS:     if (mode_ev) state_next = SET_HR;
      SET_HR:      if (mode_ev) state_next = SET_MIN;
      SET_MIN:     if (mode_ev) state_next = SET_ALM_HR;
      SET_ALM_HR:  if (mode_ev) state_next = SET_ALM_MIN;
      SET_ALM_MIN: if (mode_ev) state_next = SHOW_HM;
      default:     state_next = SHOW_HM;
    endcase
    if (timeout) state_next = SHOW_HM;
    state_chg = (state_next != state_reg);

    rep_cnt_next     = rep_cnt_reg;
    rep_started_next = rep_started_reg;
    if (!inc_held || !set_state || state_chg) begin
      rep_cnt_next     = '0;
      rep_started_next = 1'b0;
    end else if (strobe) begin
      rep_cnt_next     = '0;
      rep_started_next = 1'b1;
    end else if (tick_1kHz) begin
      rep_cnt_next     = rep_cnt_reg + RW'(1);
    end

    to_cnt_next = to_cnt_reg;
    if (!set_state || state_chg || activity) to_cnt_next = '0;
    else if (tick_1Hz)                       to_cnt_next = to_cnt_reg + TW'(1);

    // Restart the blink on entry and on every edit so the value shows at once.
    blink_cnt_next   = blink_cnt_reg;
    blank_phase_next = blank_phase_reg;
    if (state_chg || (inc_act && set_state)) begin
      blink_cnt_next   = '0;
      blank_phase_next = 1'b0;
    end else if (tick_1kHz) begin
      if (blink_cnt_reg == BW'(BLINK_MS - 1)) begin
        blink_cnt_next   = '0;
        blank_phase_next = ~blank_phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + BW'(1);
      end
    end

    adj_hr_next   = inc_act && (state_reg == SET_HR);
    adj_min_next  = inc_act && (state_reg == SET_MIN);
    alm_hr_next   = (inc_act && state_reg == SET_ALM_HR)  ? bcd_inc_hr(alm_hr_reg)   : alm_hr_reg;
    alm_min_next  = (inc_act && state_reg == SET_ALM_MIN) ? bcd_inc_min(alm_min_reg) : alm_min_reg;
    alarm_on_next = (inc_act && state_reg == SHOW_MS) ? ~alarm_on_reg : alarm_on_reg;

    // The mask follows the next state so it lines up with Mode.
    blank_mask_next = 4'b0000;
    case (state_next)
      SET_HR, SET_ALM_HR:   if (blank_phase_next) blank_mask_next = 4'b1100;
      SET_MIN, SET_ALM_MIN: if (blank_phase_next) blank_mask_next = 4'b0011;
      default:              blank_mask_next = 4'b0000;
    endcase
  end

  assign Mode      = state_reg;
  assign AdjHr     = adj_hr_reg;
  assign AdjMin    = adj_min_reg;
  assign AlmHr     = alm_hr_reg;
  assign AlmMin    = alm_min_reg;
  assign AlarmOn   = alarm_on_reg;
  assign BlankMask = blank_mask_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Directed walk through the controller's features, followed by a random
// sequence of button presses. The random results are compared with a
// decimal-arithmetic model of the mode, alarm and adjust behaviour.
module tb_clock_set_ctrl;

  logic       CP = 1'b0;
  logic       nCR, tick_1kHz, tick_1Hz, KeyMode, KeyInc;
  logic [2:0] Mode;
  logic       AdjHr, AdjMin, AlarmOn;
  logic [7:0] AlmHr, AlmMin;
  logic [3:0] BlankMask;

  int n_cmp = 0;
  int n_err = 0;
  int n_adj_hr = 0;
  int n_adj_min = 0;
  int base_hr, base_min;

  // reference model state for the random phase
  int m_mode, m_hr, m_min, m_aon, m_adj_hr, m_adj_min;

  clock_set_ctrl dut (
    .CP(CP), .nCR(nCR), .tick_1kHz(tick_1kHz), .tick_1Hz(tick_1Hz),
    .KeyMode(KeyMode), .KeyInc(KeyInc), .Mode(Mode), .AdjHr(AdjHr),
    .AdjMin(AdjMin), .AlmHr(AlmHr), .AlmMin(AlmMin), .AlarmOn(AlarmOn),
    .BlankMask(BlankMask)
  );

  always #5 CP = ~CP;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge CP);
    #1;
    if (AdjHr === 1'b1) n_adj_hr++;
    if (AdjMin === 1'b1) n_adj_min++;
    chk("adj_exclusive", {31'd0, AdjHr & AdjMin}, 32'd0);
  endtask

  task automatic press_mode();
    KeyMode = 1'b1; cyc();
    KeyMode = 1'b0; cyc();
  endtask

  task automatic press_inc();
    KeyInc = 1'b1; cyc();
    KeyInc = 1'b0; cyc();
  endtask

  task automatic tick_k(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1kHz = 1'b1; cyc();
      tick_1kHz = 1'b0; cyc();
    end
  endtask

  task automatic tick_s(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1Hz = 1'b1; cyc();
      tick_1Hz = 1'b0; cyc();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mode"},  {29'd0, Mode}, 32'd0);
    chk({tag, "_almhr"}, {24'd0, AlmHr}, 32'h07);
    chk({tag, "_almmin"}, {24'd0, AlmMin}, 32'h00);
    chk({tag, "_aon"},   {31'd0, AlarmOn}, 32'd0);
    chk({tag, "_mask"},  {28'd0, BlankMask}, 32'd0);
    chk({tag, "_adj"},   {30'd0, AdjHr, AdjMin}, 32'd0);
  endtask

  initial begin
    nCR = 1'b0; tick_1kHz = 1'b0; tick_1Hz = 1'b0; KeyMode = 1'b0; KeyInc = 1'b0;
    cyc(); cyc(); cyc();
    check_reset_state("reset");
    nCR = 1'b1; cyc();

    // mode sequence 1,2,3,4,5,0
    for (int i = 1; i <= 6; i++) begin
      press_mode();
      chk("mode_step", {29'd0, Mode}, 32'(i % 6));
    end

    // simultaneous mode+inc in SET_HR: mode wins, no AdjHr
    press_mode(); press_mode();
    chk("enter_set_hr", {29'd0, Mode}, 32'd2);
    base_hr = n_adj_hr;
    KeyMode = 1'b1; KeyInc = 1'b1; cyc();
    chk("simul_mode", {29'd0, Mode}, 32'd3);
    KeyMode = 1'b0; KeyInc = 1'b0; cyc(); cyc();
    chk("simul_no_adjhr", 32'(n_adj_hr - base_hr), 32'd0);

    // single AdjMin pulse in SET_MIN
    base_min = n_adj_min;
    press_inc();
    chk("set_min_pulse", 32'(n_adj_min - base_min), 32'd1);

    // alarm hour: 07 -> 22, then 23, 00, 01
    press_mode();
    chk("enter_alm_hr", {29'd0, Mode}, 32'd4);
    for (int i = 1; i <= 15; i++) begin
      press_inc();
      if (i == 3)  chk("almhr_09_10", {24'd0, AlmHr}, 32'h10);
      if (i == 13) chk("almhr_19_20", {24'd0, AlmHr}, 32'h20);
    end
    chk("almhr_22", {24'd0, AlmHr}, 32'h22);
    press_inc(); chk("almhr_23", {24'd0, AlmHr}, 32'h23);
    press_inc(); chk("almhr_wrap", {24'd0, AlmHr}, 32'h00);
    press_inc(); chk("almhr_01", {24'd0, AlmHr}, 32'h01);

    // alarm minute: 00 -> 58, then 59, 00
    press_mode();
    chk("enter_alm_min", {29'd0, Mode}, 32'd5);
    for (int i = 1; i <= 58; i++) begin
      press_inc();
      if (i == 10) chk("almmin_09_10", {24'd0, AlmMin}, 32'h10);
    end
    chk("almmin_58", {24'd0, AlmMin}, 32'h58);
    press_inc(); chk("almmin_59", {24'd0, AlmMin}, 32'h59);
    press_inc(); chk("almmin_wrap", {24'd0, AlmMin}, 32'h00);

    // blink on minute digits
    tick_k(249); chk("blink_min_vis", {28'd0, BlankMask}, 32'b0000);
    tick_k(1);   chk("blink_min_blank", {28'd0, BlankMask}, 32'b0011);
    tick_k(250); chk("blink_min_back", {28'd0, BlankMask}, 32'b0000);

    // auto-repeat in SET_MIN: 1100 ticks held -> 5 pulses
    press_mode(); press_mode(); press_mode(); press_mode();
    chk("enter_set_min", {29'd0, Mode}, 32'd3);
    base_min = n_adj_min;
    base_hr = n_adj_hr;
    KeyInc = 1'b1; cyc();
    chk("rep_press", 32'(n_adj_min - base_min), 32'd1);
    tick_k(499); chk("rep_before_500", 32'(n_adj_min - base_min), 32'd1);
    tick_k(1);   chk("rep_at_500", 32'(n_adj_min - base_min), 32'd2);
    tick_k(199); chk("rep_before_700", 32'(n_adj_min - base_min), 32'd2);
    tick_k(1);   chk("rep_at_700", 32'(n_adj_min - base_min), 32'd3);
    tick_k(400);
    KeyInc = 1'b0; cyc(); cyc();
    chk("rep_total", 32'(n_adj_min - base_min), 32'd5);
    chk("rep_no_adjhr", 32'(n_adj_hr - base_hr), 32'd0);

    // SET_HR: blink on hour digits, then timeout
    press_mode(); press_mode(); press_mode(); press_mode(); press_mode();
    chk("enter_set_hr2", {29'd0, Mode}, 32'd2);
    tick_k(250); chk("blink_hr_blank", {28'd0, BlankMask}, 32'b1100);
    tick_k(250); chk("blink_hr_vis", {28'd0, BlankMask}, 32'b0000);
    tick_s(9);   chk("to_tick9", {29'd0, Mode}, 32'd2);
    base_hr = n_adj_hr;
    press_inc();
    chk("to_press_pulse", 32'(n_adj_hr - base_hr), 32'd1);
    tick_s(9);   chk("to_restart", {29'd0, Mode}, 32'd2);
    tick_1Hz = 1'b1; cyc();
    chk("to_fire", {29'd0, Mode}, 32'd0);
    tick_1Hz = 1'b0; cyc();

    // SHOW_MS alarm toggle; a held press toggles only once
    press_mode();
    chk("enter_show_ms", {29'd0, Mode}, 32'd1);
    press_inc(); chk("aon_on", {31'd0, AlarmOn}, 32'd1);
    KeyInc = 1'b1; cyc();
    chk("aon_off", {31'd0, AlarmOn}, 32'd0);
    tick_k(1000);
    KeyInc = 1'b0; cyc();
    chk("aon_hold", {31'd0, AlarmOn}, 32'd0);

    // reset in SET_ALM_MIN with KeyInc pressed
    press_mode(); press_mode(); press_mode(); press_mode();
    chk("enter_alm_min2", {29'd0, Mode}, 32'd5);
    press_inc(); chk("almmin_01", {24'd0, AlmMin}, 32'h01);
    KeyInc = 1'b1; nCR = 1'b0; cyc();
    check_reset_state("midreset");
    KeyInc = 1'b0; cyc();
    nCR = 1'b1; cyc();

    // random presses vs. model
    m_mode = 0; m_hr = 7; m_min = 0; m_aon = 0;
    m_adj_hr = n_adj_hr; m_adj_min = n_adj_min;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      KeyMode = (r <= 3) || (r == 9);
      KeyInc  = (r >= 4);
      cyc();
      KeyMode = 1'b0; KeyInc = 1'b0;
      cyc();
      if (r <= 3 || r == 9) begin
        m_mode = (m_mode + 1) % 6;
      end else begin
        case (m_mode)
          1: m_aon = 1 - m_aon;
          2: m_adj_hr++;
          3: m_adj_min++;
          4: m_hr = (m_hr + 1) % 24;
          5: m_min = (m_min + 1) % 60;
          default: ;
        endcase
      end
      chk("rnd_mode", {29'd0, Mode}, 32'(m_mode));
      chk("rnd_almhr", {24'd0, AlmHr}, {24'd0, to_bcd(m_hr)});
      chk("rnd_almmin", {24'd0, AlmMin}, {24'd0, to_bcd(m_min)});
      chk("rnd_aon", {31'd0, AlarmOn}, 32'(m_aon));
      chk("rnd_adjhr", 32'(n_adj_hr), 32'(m_adj_hr));
      chk("rnd_adjmin", 32'(n_adj_min), 32'(m_adj_min));
      chk("rnd_mask", {28'd0, BlankMask}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
